// File: rtl/vga_timing_engine.sv
// vga_timing_engine: parametrised VGA raster generator.
// Produces col/row, display enable, line/frame strobes and a frame counter. Syncs and blanking
// are delayed to line up with an external colour pipeline of PIPE_DLY cycles, then the pixel is
// registered and forced to black outside the active area.
// Build macro TEST_PATTERN_EN adds a pattern_sel input and an internal 8-bar colour source.
module vga_timing_engine #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned ROW_W    = 10,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3*COLOR_W-1:0] rgb_in,
`ifdef TEST_PATTERN_EN
  input  logic                 pattern_sel,
`endif
  output logic [COL_W-1:0]     col,
  output logic [ROW_W-1:0]     row,
  output logic                 disp_ena,
  output logic                 line_start,
  output logic                 frame_start,
  output logic [FCNT_W-1:0]    frame_count,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 n_blank,
  output logic                 n_sync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive bounds keep every constant inside the counter width.
  localparam logic [COL_W-1:0] HLast      = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] HActLast   = COL_W'(H_ACTIVE - 1);
  localparam logic [COL_W-1:0] HSyncFirst = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] HSyncLast  = COL_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [ROW_W-1:0] VLast      = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] VActLast   = ROW_W'(V_ACTIVE - 1);
  localparam logic [ROW_W-1:0] VSyncFirst = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] VSyncLast  = ROW_W'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef TEST_PATTERN_EN
  localparam int unsigned DW = 7;
`else
  localparam int unsigned DW = 3;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state;
  logic [COL_W-1:0]  col_nxt;
  logic [ROW_W-1:0]  row_nxt;
  logic              de_nxt;
  logic              fs_nxt;

  // Raster position one step ahead, with line and frame wrap.
  always_comb begin
    col_nxt = col + COL_W'(1);
    row_nxt = row;
    if (col == HLast) begin
      col_nxt = '0;
      row_nxt = (row == VLast) ? '0 : row + ROW_W'(1);
    end
    de_nxt = (col_nxt <= HActLast) && (row_nxt <= VActLast);
    fs_nxt = (col_nxt == '0) && (row_nxt == '0);
  end

  // Raster FSM: counters, display enable, strobes and frame counter.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      col         <= '0;
      row         <= '0;
      disp_ena    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          col <= '0;
          row <= '0;
          if (enable) begin
            // Starting always lands on pixel (0,0) of a fresh frame.
            state       <= StRun;
            disp_ena    <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            frame_count <= frame_count + FCNT_W'(1);
          end else begin
            disp_ena    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
          end
        end
        StRun: begin
          if (!enable) begin
            state       <= StIdle;
            col         <= '0;
            row         <= '0;
            disp_ena    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
          end else begin
            col         <= col_nxt;
            row         <= row_nxt;
            disp_ena    <= de_nxt;
            line_start  <= (col_nxt == '0);
            frame_start <= fs_nxt;
            if (fs_nxt) begin
              frame_count <= frame_count + FCNT_W'(1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Sync windows are decoded as active flags; polarity is applied at the output register.
  logic hs_act;
  logic vs_act;
  assign hs_act = (col >= HSyncFirst) && (col <= HSyncLast);
  assign vs_act = (row >= VSyncFirst) && (row <= VSyncLast);

  logic [DW-1:0] pipe_in;
  logic [DW-1:0] pipe_out;

`ifdef TEST_PATTERN_EN
  localparam logic [COL_W+2:0] HActDiv = (COL_W + 3)'(H_ACTIVE);
  logic [COL_W+2:0] bar_full;
  assign bar_full = {col, 3'b000} / HActDiv;
  // Pattern select and bar index travel with col so they meet rgb_in's latency.
  assign pipe_in  = {pattern_sel, bar_full[2:0], hs_act, vs_act, disp_ena};
`else
  assign pipe_in  = {hs_act, vs_act, disp_ena};
`endif

  if (PIPE_DLY == 0) begin : g_no_dly
    assign pipe_out = pipe_in;
  end else begin : g_dly
    logic [DW-1:0] stage_q [PIPE_DLY];

    // Shift register matching the external colour logic latency; resets to inactive.
    always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q[0] <= pipe_in;
        for (int i = 1; i < int'(PIPE_DLY); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign pipe_out = stage_q[PIPE_DLY-1];
  end

  logic                 hs_d;
  logic                 vs_d;
  logic                 de_d;
  logic [3*COLOR_W-1:0] pix_src;

  assign {hs_d, vs_d, de_d} = pipe_out[2:0];

`ifdef TEST_PATTERN_EN
  logic       sel_d;
  logic [2:0] bar_d;
  assign {sel_d, bar_d} = pipe_out[6:3];
  assign pix_src = sel_d ? {{COLOR_W{bar_d[2]}}, {COLOR_W{bar_d[1]}}, {COLOR_W{bar_d[0]}}}
                         : rgb_in;
`else
  assign pix_src = rgb_in;
`endif

  // Output register: syncs with polarity, blanking and black outside the active area.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_sync  <= ~H_POL;
      v_sync  <= ~V_POL;
      n_blank <= 1'b0;
      n_sync  <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      h_sync  <= hs_d ? H_POL : ~H_POL;
      v_sync  <= vs_d ? V_POL : ~V_POL;
      n_blank <= de_d;
      n_sync  <= 1'b0;
      red     <= de_d ? pix_src[3*COLOR_W-1:2*COLOR_W] : '0;
      green   <= de_d ? pix_src[2*COLOR_W-1:COLOR_W]   : '0;
      blue    <= de_d ? pix_src[COLOR_W-1:0]           : '0;
    end
  end

endmodule
